board_eval: RTL
===============

Name: board_eval

Overview:
- Consumer of the boards written by the move-generator blocks (pawn, rook, etc.).
- Reads N consecutive 64-square boards from SDRAM over an Avalon-MM master and computes a signed material score for each board (white minus black).
- Tracks the highest-scoring board.
- Configured and polled by the HPS over an Avalon-MM slave, using the same register and start/poll handshake as the generators.

Parameters:
- MAX_BOARDS, 12, upper bound on the board-count register; larger values are clamped to it.
- SQUARES, 64, squares per board (bytes per board).

Ports:
- clk input 1 system clock
- rst_n input 1 asynchronous active-low reset
- slave_waitrequest output 1 slave stall
- slave_address input 4 register select
- slave_read input 1 slave read strobe
- slave_readdata output 32 register read data
- slave_write input 1 slave write strobe
- slave_writedata input 32 register write data
- master_waitrequest input 1 master stall
- master_address output 32 byte address
- master_read output 1 master read strobe
- master_readdata input 32 read data; square code in bits [7:0], signed
- master_readdatavalid input 1 read data valid
- master_write output 1 tied 0
- master_writedata output 32 tied 0

Behaviour:
- Reset values: all outputs 0; slave_waitrequest 1 for the duration of reset.
- Registers, all 32 bit:
  - 1 board_base, R/W
  - 2 num_boards, R/W
  - 3 best_index, RO, reset 0xFFFFFFFF
  - 4 best_score, RO, reset 0x80000000
  - 5 last_score, RO
- Register 0 writes:
  - Starts a run when the block is IDLE.
  - Ignored while busy.
- Register 0 reads:
  - slave_waitrequest is held high until state DONE.
  - The read then completes in 1 cycle and returns 1; state goes DONE -> IDLE.
- Writes to registers 1/2:
  - Complete with waitrequest low in the same cycle.
  - Values are latched at start, so writes during a run do not affect that run.
- Run start:
  - Clears best_index to 0xFFFFFFFF and best_score to 0x80000000.
  - num_boards==0 goes straight to DONE.
- Piece values, by code magnitude:
  - 1-8 pawn = 1
  - 9-18 rook = 5
  - 19-28 knight = 3
  - 29-38 bishop = 3
  - 39-47 queen = 9
  - 48 king = 0
  - 0 empty
  - Any other code (e.g. 0xFF) counts 0.
  - Positive codes add to the score; negative codes subtract.
- State machine: IDLE -> REQ -> WAIT -> ACC -> (REQ | NEXT) -> (REQ | DONE) -> IDLE.
  - REQ: master_read=1, master_address = board_base + 64*k + sq. Held stable until master_waitrequest=0.
  - WAIT: data is captured on the first master_readdatavalid=1 cycle strictly after the accept cycle. Exactly one read is outstanding at a time.
  - ACC: accumulate the square into a 16-bit signed running score. sq 0..63; at sq==63 go to NEXT.
  - NEXT: last_score = score (sign-extended). If score > best_score (strict), update best_score and best_index=k, so ties keep the lower index. Then k++, clear score, and go to DONE when k == num_boards.
- Latency per board: at least 64*(3 cycles + memory latency) + 1.
- Reset mid-run: asynchronously abort the run; return to IDLE with reset register values.

Optional Feature:
- Macro KING_CAPTURE_EN.
- Defined:
  - A board with no code -48 (black king) scores +1000.
  - A board with no code 48 (white king) scores -1000.
  - A board missing both kings scores 0.
  - Otherwise the material score applies.
  - King presence is tracked per board with two flags cleared in NEXT.
- Undefined: king codes are ignored; material score only.

Test Plan:
- Standard opening board at base 0, num_boards=1 -> last_score 0, best_index 0, best_score 0.
- Two boards at base 0x100: board0 has white queen removed, board1 has black rook removed -> scores -9 and +5; best_index 1, best_score 5.
- Two identical boards scoring +3 -> best_index 0 (tie keeps the first).
- num_boards=0 start, then poll register 0 -> readdata 1 within 3 cycles; best_index 0xFFFFFFFF.
- master_waitrequest held high for 5 cycles on each request, and readdatavalid delayed 2 cycles -> address stable while stalled; result equals the no-stall result.
- With KING_CAPTURE_EN, a board lacking code -48 -> last_score 1000. Reset asserted mid-run -> slave_waitrequest 1 during reset, IDLE afterwards, best_index 0xFFFFFFFF.

Source files
------------

// File: rtl/board_eval_if.sv
// board_eval_if: Avalon-MM CSR slave and SDRAM read-master signals of board_eval
interface board_eval_if;
   logic        slave_waitrequest;
   logic [3:0]  slave_address;
   logic        slave_read;
   logic [31:0] slave_readdata;
   logic        slave_write;
   logic [31:0] slave_writedata;
   logic        master_waitrequest;
   logic [31:0] master_address;
   logic        master_read;
   logic [31:0] master_readdata;
   logic        master_readdatavalid;
   logic        master_write;
   logic [31:0] master_writedata;
   // board_eval side
   modport slave (
      output slave_waitrequest, slave_readdata, master_address, master_read, master_write, master_writedata,
      input  slave_address, slave_read, slave_write, slave_writedata,
      input  master_waitrequest, master_readdata, master_readdatavalid
   );
   // host and memory side
   modport master (
      input  slave_waitrequest, slave_readdata, master_address, master_read, master_write, master_writedata,
      output slave_address, slave_read, slave_write, slave_writedata,
      output master_waitrequest, master_readdata, master_readdatavalid
   );
endinterface

// File: rtl/board_eval.sv
// board_eval: scores N boards read over Avalon-MM (white minus black), tracks the best; define KING_CAPTURE_EN for king-capture scoring
module board_eval #(
   parameter int MAX_BOARDS = 12,
   parameter int SQUARES    = 64
) (
   input logic         clk,
   input logic         rst_n,
   board_eval_if.slave bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, ACC, NEXT, DONE} state_t;
   state_t             state_q, state_d;
   logic               rdy_q;
   logic [31:0]        base_q, base_d, nb_q, nb_d, run_base_q, run_base_d, run_nb_q, run_nb_d;
   logic [31:0]        k_q, k_d, sq_q, sq_d, addr_q, addr_d;
   logic [31:0]        best_idx_q, best_idx_d, best_score_q, best_score_d, last_q, last_d;
   logic               rd_q, rd_d;
   logic [7:0]         data_q, data_d;
   logic signed [15:0] score_q, score_d, final_score;
   logic [31:0]        final_ext;
   logic               csr_wr, start, done_rd, unused_bits;
`ifdef KING_CAPTURE_EN
   logic               wk_q, wk_d, bk_q, bk_d;
`endif

   function automatic logic signed [15:0] piece(input logic [7:0] c);
      logic [7:0]         m;
      logic signed [15:0] v;
      m = c[7] ? 8'(-c) : c;
      v = (m >= 8'd1  && m <= 8'd8)  ? 16'sd1 :
          (m >= 8'd9  && m <= 8'd18) ? 16'sd5 :
          (m >= 8'd19 && m <= 8'd38) ? 16'sd3 :
          (m >= 8'd39 && m <= 8'd47) ? 16'sd9 : 16'sd0;
      return c[7] ? -v : v;
   endfunction

   assign csr_wr  = rdy_q && bus.slave_write;
   assign start   = csr_wr && bus.slave_address == 4'd0 && state_q == IDLE;
   assign done_rd = rdy_q && bus.slave_read && bus.slave_address == 4'd0 && state_q == DONE;
   assign bus.slave_waitrequest = !rdy_q || (bus.slave_read && bus.slave_address == 4'd0 && state_q != DONE);
   assign bus.slave_readdata = !(rdy_q && bus.slave_read) ? 32'd0 :
                               bus.slave_address == 4'd0 ? {31'd0, state_q == DONE} :
                               bus.slave_address == 4'd1 ? base_q :
                               bus.slave_address == 4'd2 ? nb_q :
                               bus.slave_address == 4'd3 ? best_idx_q :
                               bus.slave_address == 4'd4 ? best_score_q :
                               bus.slave_address == 4'd5 ? last_q : 32'd0;
   assign bus.master_read      = rd_q;
   assign bus.master_address   = addr_q;
   assign bus.master_write     = 1'b0;
   assign bus.master_writedata = 32'd0;
   assign unused_bits          = ^bus.master_readdata[31:8];
`ifdef KING_CAPTURE_EN
   assign final_score = (!wk_q && !bk_q) ? 16'sd0 : !bk_q ? 16'sd1000 : !wk_q ? -16'sd1000 : score_q;
`else
   assign final_score = score_q;
`endif
   assign final_ext = {{16{final_score[15]}}, final_score};

   // next-state: CSR writes, run sequencing, score accumulation and best tracking
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      nb_d         = nb_q;
      run_base_d   = run_base_q;
      run_nb_d     = run_nb_q;
      k_d          = k_q;
      sq_d         = sq_q;
      data_d       = data_q;
      score_d      = score_q;
      last_d       = last_q;
      best_idx_d   = best_idx_q;
      best_score_d = best_score_q;
`ifdef KING_CAPTURE_EN
      wk_d         = wk_q;
      bk_d         = bk_q;
`endif
      if (csr_wr && bus.slave_address == 4'd1) base_d = bus.slave_writedata;
      if (csr_wr && bus.slave_address == 4'd2)
         nb_d = bus.slave_writedata > 32'(MAX_BOARDS) ? 32'(MAX_BOARDS) : bus.slave_writedata;
      case (state_q)
         IDLE: if (start) begin
            run_base_d   = base_q;
            run_nb_d     = nb_q;
            k_d          = 32'd0;
            sq_d         = 32'd0;
            score_d      = 16'sd0;
            best_idx_d   = 32'hFFFF_FFFF;
            best_score_d = 32'h8000_0000;
`ifdef KING_CAPTURE_EN
            wk_d         = 1'b0;
            bk_d         = 1'b0;
`endif
            state_d      = nb_q == 32'd0 ? DONE : REQ;
         end
         REQ:  state_d = bus.master_waitrequest ? REQ : WAIT;
         WAIT: if (bus.master_readdatavalid) begin
            data_d  = bus.master_readdata[7:0];
            state_d = ACC;
         end
         ACC: begin
            score_d = score_q + piece(data_q);
`ifdef KING_CAPTURE_EN
            wk_d    = wk_q || data_q == 8'd48;
            bk_d    = bk_q || data_q == 8'hD0;
`endif
            sq_d    = sq_q == 32'(SQUARES - 1) ? 32'd0 : sq_q + 32'd1;
            state_d = sq_q == 32'(SQUARES - 1) ? NEXT : REQ;
         end
         NEXT: begin
            last_d = final_ext;
            if ($signed(final_ext) > $signed(best_score_q)) begin
               best_score_d = final_ext;
               best_idx_d   = k_q;
            end
            k_d     = k_q + 32'd1;
            score_d = 16'sd0;
`ifdef KING_CAPTURE_EN
            wk_d    = 1'b0;
            bk_d    = 1'b0;
`endif
            state_d = k_q + 32'd1 == run_nb_q ? DONE : REQ;
         end
         DONE:    state_d = done_rd ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
      rd_d   = state_d == REQ;
      addr_d = run_base_d + k_d * 32'(SQUARES) + sq_d;
   end

   // state and registered bus outputs; reset aborts any run
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q      <= IDLE;
         rdy_q        <= 1'b0;
         base_q       <= 32'd0;
         nb_q         <= 32'd0;
         run_base_q   <= 32'd0;
         run_nb_q     <= 32'd0;
         k_q          <= 32'd0;
         sq_q         <= 32'd0;
         addr_q       <= 32'd0;
         rd_q         <= 1'b0;
         data_q       <= 8'd0;
         score_q      <= 16'sd0;
         last_q       <= 32'd0;
         best_idx_q   <= 32'hFFFF_FFFF;
         best_score_q <= 32'h8000_0000;
`ifdef KING_CAPTURE_EN
         wk_q         <= 1'b0;
         bk_q         <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rdy_q        <= 1'b1;
         base_q       <= base_d;
         nb_q         <= nb_d;
         run_base_q   <= run_base_d;
         run_nb_q     <= run_nb_d;
         k_q          <= k_d;
         sq_q         <= sq_d;
         addr_q       <= addr_d;
         rd_q         <= rd_d;
         data_q       <= data_d;
         score_q      <= score_d;
         last_q       <= last_d;
         best_idx_q   <= best_idx_d;
         best_score_q <= best_score_d;
`ifdef KING_CAPTURE_EN
         wk_q         <= wk_d;
         bk_q         <= bk_d;
`endif
      end
endmodule
